// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl -- ring-oscillator measurement controller.
//
// Enables the ring, waits SETTLE_CYC clocks for it to settle, then counts
// synchronized rising edges of ro_in over win_len clocks. The result is
// held with valid until acknowledged.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start, win_len  measurement request and window length (IDLE only)
//   ro_in           oscillator output (asynchronous to clk, f_ro < f_clk/2)
//   ro_en           ring enable (this block is its only driver)
//   busy            high in SETTLE, MEASURE and DONE
//   valid, ack      result handshake
//   count, ovf      edge count and saturation flag
//
// Optional feature macro: RO_MEAS_CONT_EN
//   When defined, an ack that coincides with start in DONE restarts directly
//   in MEASURE with the ring kept running (no SETTLE). When undefined, every
//   run returns to IDLE and the ring is switched off in DONE.
`timescale 1ns/1ps

// Synchronizer plus rising-edge detect for the oscillator input.
module ro_meas_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign rise = sr[STAGES-1] & ~prev;
endmodule

module ro_meas_ctrl #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             valid,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  // Timer runs down to zero, so it is loaded with length-1.
  localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE_CYC - 1);

  state_t           state;
  logic [WIN_W-1:0] tmr;
  logic [WIN_W-1:0] win_lat;
  logic             rise;

  // The synchronizer runs in every state; only MEASURE looks at rise.
  ro_meas_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ro_in),
    .rise (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      win_lat <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      ro_en   <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (win_len != '0)) begin
            win_lat <= win_len;
            tmr     <= SETTLE_LD;
            count   <= '0;
            ovf     <= 1'b0;
            ro_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end

        SETTLE: begin
          if (tmr == '0) begin
            tmr   <= win_lat - 1'b1;
            state <= MEASURE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        MEASURE: begin
          if (rise) begin
            if (count == CNT_MAX) ovf   <= 1'b1;
            else                  count <= count + 1'b1;
          end
          if (tmr == '0) begin
            state <= DONE;
`ifndef RO_MEAS_CONT_EN
            ro_en <= 1'b0;
`endif
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        DONE: begin
          // valid rises one cycle after entering DONE; ack only counts once
          // the consumer has actually seen it.
          if (valid && ack) begin
            valid <= 1'b0;
`ifdef RO_MEAS_CONT_EN
            if (start && (win_len != '0)) begin
              win_lat <= win_len;
              tmr     <= win_len - 1'b1;
              count   <= '0;
              ovf     <= 1'b0;
              state   <= MEASURE;
            end else begin
              ro_en <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end else begin
            valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
